// File: rtl/ifq_param.sv
// ifq_param: parametrised line-buffering instruction fetch queue; define IFQ_BYPASS_EN for same-cycle bypass into an empty queue
module ifq_param #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [31:0]               Pc_in,
  output logic                      Rd_en_cache,
  input  logic [32*LINE_WORDS-1:0]  Dout,
  input  logic                      Dout_valid,
  output logic [31:0]               Inst,
  output logic [31:0]               Pc_out,
  output logic                      Empty,
  input  logic                      Rd_en,
  input  logic [31:0]               Jmp_branch_address,
  input  logic                      Jmp_branch_valid,
  output logic [$clog2(DEPTH):0]    Count
);
  localparam int OFF = $clog2(LINE_WORDS);
  localparam int WW = OFF > 0 ? OFF : 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [29:0] LMASK = 30'(LINE_WORDS - 1);
  typedef enum logic {FETCH, SQUASH} state_t;
  state_t state;
  logic [29:0] fpc;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [WW-1:0] rd_word;
  logic [31:0] mem [DEPTH][LINE_WORDS];
  logic [31:0] base [DEPTH];
  logic [31:0] inst_q, pc_q, word, line_base;
  logic wr, pop, last, byp, unused;
  assign unused = ^Jmp_branch_address[1:0];
  assign Pc_in = {fpc & ~LMASK, 2'b00};
  assign Rd_en_cache = state == FETCH && Count != (PW+1)'(DEPTH);
  assign wr = Rd_en_cache && Dout_valid && !Jmp_branch_valid;
`ifdef IFQ_BYPASS_EN
  assign byp = Count == '0 && wr;
`else
  assign byp = 1'b0;
`endif
  assign Empty = Count == '0 && !byp;
  assign pop = Rd_en && !Empty && !Jmp_branch_valid;
  assign last = rd_word == WW'(LINE_WORDS - 1);
  assign word = byp ? Dout[{rd_word, 5'b0} +: 32] : mem[rd_ptr][rd_word];
  assign line_base = byp ? Pc_in : base[rd_ptr];
  assign Inst = Empty ? inst_q : word;
  assign Pc_out = Empty ? pc_q : line_base + 32'({rd_word, 2'b00}) + 32'd4;
  always_ff @(posedge clock) begin
    if (wr) begin
      for (int i = 0; i < LINE_WORDS; i++) mem[wr_ptr][i] <= Dout[32*i +: 32];
      base[wr_ptr] <= Pc_in;
    end
  end
  // rd_word is preloaded with the target's word offset so the first line lands already skipped
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= FETCH;
      fpc <= RESET_PC[31:2];
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_word <= '0;
      Count <= '0;
      inst_q <= '0;
      pc_q <= '0;
    end else if (Jmp_branch_valid) begin
      state <= SQUASH;
      fpc <= Jmp_branch_address[31:2];
      wr_ptr <= '0;
      rd_ptr <= '0;
      rd_word <= WW'(Jmp_branch_address[31:2] & LMASK);
      Count <= '0;
    end else begin
      state <= FETCH;
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        fpc <= fpc + 30'(LINE_WORDS);
      end
      if (pop) begin
        rd_word <= last ? '0 : rd_word + 1'b1;
        if (last) rd_ptr <= rd_ptr + 1'b1;
      end
      Count <= Count + (PW+1)'(wr) - (PW+1)'(pop && last);
      if (!Empty) begin
        inst_q <= Inst;
        pc_q <= Pc_out;
      end
    end
  end
endmodule

// File: tb/tb_ifq_param.sv
// tb_ifq_param: random/directed bench; expected stream is sequential addresses from the last redirect target
`timescale 1ns/1ps
module tb_ifq_param;
  localparam int LW = 4;
  localparam int DEPTH = 4;
  logic clock = 0, reset = 1;
  logic [31:0] Pc_in, Inst, Pc_out, Jmp_branch_address = '0;
  logic Rd_en_cache, Empty, Dout_valid = 0, Rd_en = 0, Jmp_branch_valid = 0;
  logic [32*LW-1:0] Dout = '0;
  logic [2:0] Count;
  int tests = 0, fails = 0, dv_p = 0, rd_p = 0;
  logic [31:0] sb[$];
  logic [31:0] next_pc;
  always #5 clock = ~clock;
  ifq_param #(.LINE_WORDS(LW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .Pc_in(Pc_in), .Rd_en_cache(Rd_en_cache),
    .Dout(Dout), .Dout_valid(Dout_valid), .Inst(Inst), .Pc_out(Pc_out),
    .Empty(Empty), .Rd_en(Rd_en), .Jmp_branch_address(Jmp_branch_address),
    .Jmp_branch_valid(Jmp_branch_valid), .Count(Count)
  );
  function automatic logic [31:0] f(input logic [31:0] a);
    logic [31:0] r;
    case (a)
      32'h0, 32'hC: r = 32'h0000_0020;
      32'h4: r = 32'h0080_F820;
      32'h8: r = 32'h00BF_1019;
      default: r = (a * 32'h9E37_79B1) ^ 32'h5EED_1234;
    endcase
    return r;
  endfunction
  function automatic logic [32*LW-1:0] line_of(input logic [31:0] a);
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = f(a + 32'(4*i));
    return l;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic start_stream(input logic [31:0] a);
    sb.delete();
    next_pc = {a[31:2], 2'b00};
    for (int i = 0; i < 16; i++) begin
      sb.push_back(next_pc);
      next_pc += 32'd4;
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
    Dout_valid = $urandom_range(99) < dv_p;
    Rd_en = $urandom_range(99) < rd_p;
    Jmp_branch_valid = 0;
    Dout = line_of(Pc_in);
  endtask
  task automatic redirect(input logic [31:0] a);
    Jmp_branch_valid = 1;
    Jmp_branch_address = a;
    start_stream(a);
  endtask
  initial begin
    logic [31:0] a;
    forever begin
      @(negedge clock);
      if (!reset && !Jmp_branch_valid && Rd_en && !Empty) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          a = sb.pop_front();
          if (sb.size() < 4) begin
            sb.push_back(next_pc);
            next_pc += 32'd4;
          end
          chk("stream_inst", Inst, f(a));
          chk("stream_pc_out", Pc_out, a + 32'd4);
        end
      end
    end
  end
  initial begin
    start_stream(32'h0);
    repeat (2) cyc();
    reset = 0;
    @(negedge clock);
    chk("rst_empty", Empty, 1);
    chk("rst_count", Count, 0);
    chk("rst_rd_en_cache", Rd_en_cache, 1);
    chk("rst_pc_in", Pc_in, 0);
    chk("rst_inst", Inst, 0);
    chk("rst_pc_out", Pc_out, 0);
    dv_p = 100;
    rd_p = 100;
    cyc();
    @(negedge clock);
`ifdef IFQ_BYPASS_EN
    chk("byp_empty", Empty, 0);
    chk("byp_inst0", Inst, 32'h0000_0020);
`endif
    cyc();
    @(negedge clock);
    chk("seq_pc_in", Pc_in, 32'h10);
    chk("seq_count", Count, 1);
`ifdef IFQ_BYPASS_EN
    chk("byp_inst1", Inst, 32'h0080_F820);
`endif
    repeat (20) cyc();
    rd_p = 0;
    cyc();
    reset = 1;
    start_stream(32'h0);
    cyc();
    reset = 0;
    repeat (8) cyc();
    @(negedge clock);
    chk("full_count", Count, 4);
    chk("full_rd_en_cache", Rd_en_cache, 0);
    chk("full_pc_in", Pc_in, 32'h40);
    chk("full_empty", Empty, 0);
    repeat (3) cyc();
    @(negedge clock);
    chk("full_pc_hold", Pc_in, 32'h40);
    chk("full_count_hold", Count, 4);
    rd_p = 100;
    repeat (4) cyc();
    rd_p = 0;
    cyc();
    @(negedge clock);
    chk("free_count", Count, 3);
    chk("free_rd_en_cache", Rd_en_cache, 1);
    cyc();
    @(negedge clock);
    chk("refill_count", Count, 4);
    cyc();
    redirect(32'h48);
    cyc();
    @(negedge clock);
    chk("redir_empty", Empty, 1);
    chk("redir_count", Count, 0);
    chk("redir_squash", Rd_en_cache, 0);
    cyc();
    @(negedge clock);
    chk("redir_refetch", Rd_en_cache, 1);
    chk("redir_pc_in", Pc_in, 32'h40);
    cyc();
    @(negedge clock);
    chk("redir_inst", Inst, f(32'h48));
    chk("redir_pc_out", Pc_out, 32'h4C);
    chk("redir_line_count", Count, 1);
    cyc();
    Dout_valid = 1;
    Rd_en = 1;
    redirect(32'h206);
    @(negedge clock);
    chk("coinc_pre_rd_en_cache", Rd_en_cache, 1);
    chk("coinc_pre_empty", Empty, 0);
    dv_p = 0;
    cyc();
    @(negedge clock);
    chk("coinc_count", Count, 0);
    chk("coinc_empty", Empty, 1);
    cyc();
    @(negedge clock);
    chk("coinc_pc_in", Pc_in, 32'h200);
    dv_p = 100;
    rd_p = 100;
    repeat (30) cyc();
    dv_p = 0;
    repeat (20) cyc();
    @(negedge clock);
    chk("mid_rd_en_cache", Rd_en_cache, 1);
    chk("mid_empty", Empty, 1);
    cyc();
    reset = 1;
    start_stream(32'h0);
    cyc();
    reset = 0;
    @(negedge clock);
    chk("rst2_empty", Empty, 1);
    chk("rst2_count", Count, 0);
    chk("rst2_pc_in", Pc_in, 32'h0);
    for (int s = 0; s < 30; s++) begin
      dv_p = $urandom_range(100);
      rd_p = $urandom_range(100);
      if (s % 2 == 0) begin
        cyc();
        redirect(s % 6 == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : $urandom());
      end
      repeat (40) begin
        cyc();
        if ($urandom_range(99) < 3) redirect($urandom());
        @(negedge clock);
        chk("count_bound", 32'(Count <= 3'(DEPTH)), 32'd1);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ifq_param.md
Name: ifq_param

Overview:
- Parametrised instruction fetch queue sitting between i_cache and dispatch_unit in the Tomasulo MIPS core.
- Successor to the fixed 4-word ifq, generalised in three ways:
  - configurable line width (words per cache line);
  - configurable queue depth;
  - configurable reset PC.
- Adds a line-occupancy output and a redirect squash cycle.
- Buffers whole cache lines on the write side and hands one instruction per pop to dispatch on the read side.

Parameters:
- LINE_WORDS, 4: 32-bit words per cache line; power of two, 1..8. OFF = log2(LINE_WORDS).
- DEPTH, 4: line entries in the queue; power of two, 2..16.
- RESET_PC, 32'h0: fetch address loaded at reset; must be word aligned.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Pc_in  out  32  line-aligned cache request address: {fetch_pc[31:OFF+2], (OFF+2)'b0}.
- Rd_en_cache  out  1  cache request valid.
- Dout  in  32*LINE_WORDS  cache line; word i occupies bits [32i+31:32i].
- Dout_valid  in  1  Dout is valid for the current Pc_in.
- Inst  out  32  instruction at the queue head.
- Pc_out  out  32  head instruction address + 4.
- Empty  out  1  no instruction available.
- Rd_en  in  1  pop the head instruction; ignored while Empty = 1.
- Jmp_branch_address  in  32  redirect target.
- Jmp_branch_valid  in  1  redirect strobe.
- Count  out  log2(DEPTH)+1  number of valid lines held.

Behaviour:
- Reset (synchronous, evaluated every edge, highest priority):
  - fetch_pc = RESET_PC; wr_ptr, rd_ptr, rd_word, Count = 0.
  - State = FETCH.
  - Outputs after reset: Empty = 1, Rd_en_cache = 1, Pc_in = RESET_PC line-aligned, Inst = 0, Pc_out = 0.
- Storage:
  - DEPTH line entries, each holding LINE_WORDS words plus a base address.
  - Pointers wrap modulo DEPTH.
  - Count distinguishes full from empty.
- State machine:
  - FETCH: Rd_en_cache = (Count < DEPTH).
  - SQUASH: Rd_en_cache = 0; Dout_valid is ignored; always returns to FETCH on the next cycle.
  - Jmp_branch_valid in any state moves to SQUASH.
- Line write (cycle where state = FETCH, Rd_en_cache = 1, Dout_valid = 1, and no Jmp_branch_valid):
  - Write Dout and the line base address at wr_ptr.
  - wr_ptr + 1; fetch_pc + 4*LINE_WORDS, wrapping modulo 2^32.
  - Pc_in is held stable while Rd_en_cache = 1 and Dout_valid = 0. Any cache latency of 0..N cycles is tolerated.
- Read side:
  - Inst = entry[rd_ptr].word[rd_word].
  - Pc_out = entry base + 4*rd_word + 4.
  - Empty = (Count == 0), registered state only.
  - A pop with rd_word = LINE_WORDS-1 sets rd_word = 0 and increments rd_ptr; otherwise it increments rd_word.
  - A line is freed, and Count decremented, when its last word pops.
- Simultaneous line write and line free in one cycle: Count unchanged, both pointers move.
- Full:
  - Rd_en_cache is computed from registered Count, so the cache is never written while Count = DEPTH.
  - A free in the full cycle re-enables the request on the next cycle.
- Redirect (Jmp_branch_valid = 1):
  - Has priority over pop and line write in the same cycle.
  - Next edge:
    - Count, wr_ptr, rd_ptr = 0.
    - fetch_pc = {Jmp_branch_address[31:2], 2'b00}.
    - start_word = Jmp_branch_address[OFF+1:2].
  - The first line written after a redirect sets rd_word = start_word; the words below start_word are never presented.
  - Empty = 1 on the cycle after the redirect.
- Redirect during SQUASH: restarts SQUASH with the newest target.
- Inst and Pc_out hold their last value while Empty = 1 and are don't-care for checking.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When Count = 0 and a line write occurs, Empty = 0 combinationally in that cycle.
  - Inst and Pc_out are driven directly from Dout at start_word (or word 0).
  - A Rd_en in that cycle consumes that word. The line is still written, with rd_word advanced; for LINE_WORDS = 1 the line is not stored.
- Undefined: the first instruction of a newly written line is visible one cycle after the write.

Test Plan:
- Sequential fetch and pop:
  - Setup: LINE_WORDS = 4, DEPTH = 4. After reset, the cache returns the line at 0x0 one cycle after each request: {0x00000020, 0x0080F820, 0x00BF1019, 0x00000020}. Rd_en = 1 continuously.
  - Expected: Inst sequence matches those words; Pc_out = 0x4, 0x8, 0xC, 0x10; Pc_in advances to 0x10.
- Fill to full:
  - Stimulus: Rd_en = 0 with Dout_valid always 1.
  - Expected: Count = 4 after 4 lines; Rd_en_cache = 0; Pc_in held at 0x40.
- Pop one line while full:
  - Stimulus: pop 4 words.
  - Expected: Count = 3; Rd_en_cache = 1 on the next cycle.
- Redirect to 0x48 while full:
  - Expected: next cycle Empty = 1, Count = 0, Rd_en_cache = 0 for exactly one cycle, then Pc_in = 0x40.
  - After the line returns: first Inst = word 2, Pc_out = 0x4C.
- Redirect coinciding with Dout_valid and Rd_en:
  - Expected: the line is discarded and the pop has no effect; Count = 0; the next Pc_in is the target line.
- Reset mid-request:
  - Stimulus: assert reset while Rd_en_cache = 1 and Dout_valid = 0.
  - Expected: next cycle Empty = 1, Count = 0, Pc_in = RESET_PC.
- With IFQ_BYPASS_EN defined:
  - Stimulus: line write on an empty queue together with Rd_en.
  - Expected: Inst = word 0 in the same cycle; Count = 1; next Inst = word 1.
